// File: rtl/pavana_reorder_seq_if.sv
// pavana_reorder_seq_if
// Bundles the request-tag push port, the out-of-order response port and the
// in-order response/status outputs of pavana_reorder_seq.
//   slave  modport: the sequencer's view (pushes/responses in, in-order out)
//   master modport: the crossbar/slave side view (drives pushes/responses)
// Signals:
//   tag_wr_i/tag_wdata_bi      push issued read tag
//   tag_full_o/count_o         tag FIFO status (registered count)
//   resp_i/resp_tag_bi/resp_data_bi  out-of-order response
//   resp_o/resp_data_bo        in-order response (registered)
//   err_o                      sticky errors {empty resp, dup resp, push full}
interface pavana_reorder_seq_if #(
  parameter int TAG_WIDTH       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ORDER_DEPTH_LOG = 3
);
  logic                       tag_wr_i;
  logic [TAG_WIDTH-1:0]       tag_wdata_bi;
  logic                       tag_full_o;
  logic [ORDER_DEPTH_LOG:0]   count_o;
  logic                       resp_i;
  logic [TAG_WIDTH-1:0]       resp_tag_bi;
  logic [DATA_WIDTH-1:0]      resp_data_bi;
  logic                       resp_o;
  logic [DATA_WIDTH-1:0]      resp_data_bo;
  logic [2:0]                 err_o;

  modport slave (
    input  tag_wr_i, tag_wdata_bi, resp_i, resp_tag_bi, resp_data_bi,
    output tag_full_o, count_o, resp_o, resp_data_bo, err_o
  );

  modport master (
    output tag_wr_i, tag_wdata_bi, resp_i, resp_tag_bi, resp_data_bi,
    input  tag_full_o, count_o, resp_o, resp_data_bo, err_o
  );
endinterface

// File: rtl/pavana_reorder_seq.sv
// pavana_reorder_seq
// Response re-ordering sequencer. Issued read tags are queued in a circular
// FIFO; out-of-order responses are parked in one slot per tag and released
// strictly in issue order, at most one per cycle.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-low reset
//   bus    pavana_reorder_seq_if.slave (tag push, responses, status, errors)
module pavana_reorder_seq #(
  parameter int TAG_WIDTH       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ORDER_DEPTH_LOG = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pavana_reorder_seq_if.slave  bus
);
  localparam int DEPTH = 1 << ORDER_DEPTH_LOG;
  localparam int SLOTS = 1 << TAG_WIDTH;
  localparam logic [ORDER_DEPTH_LOG:0] FULL_COUNT = (ORDER_DEPTH_LOG+1)'(DEPTH);

  logic [TAG_WIDTH-1:0]       tag_fifo [DEPTH];
  logic [ORDER_DEPTH_LOG-1:0] wr_ptr;
  logic [ORDER_DEPTH_LOG-1:0] rd_ptr;
  logic [ORDER_DEPTH_LOG:0]   count;
  logic [SLOTS-1:0]           slot_valid;
  logic [DATA_WIDTH-1:0]      slot_data [SLOTS];
  logic                       resp_q;
  logic [DATA_WIDTH-1:0]      resp_data_q;
  logic [2:0]                 err_q;

  logic                 full;
  logic                 empty;
  logic [TAG_WIDTH-1:0] head;
  logic                 head_valid;
  logic                 bypass;
  logic                 release_en;
  logic                 push_ok;
  logic                 capture;
  logic                 err_full;
  logic                 err_dup;
  logic                 err_empty;

  always_comb begin
    full       = (count == FULL_COUNT);
    empty      = (count == '0);
    head       = tag_fifo[rd_ptr];
    head_valid = slot_valid[head];
    // A response for the head tag that is not already parked goes straight
    // out without ever touching the slot.
    bypass     = bus.resp_i & ~empty & ~head_valid & (bus.resp_tag_bi == head);
    release_en = ~empty & (head_valid | bypass);
    // Full is judged on the registered count: a pop in the same cycle does
    // not make room for the push.
    push_ok    = bus.tag_wr_i & ~full;
    err_full   = bus.tag_wr_i & full;
    err_empty  = bus.resp_i & empty;
    err_dup    = bus.resp_i & ~empty & slot_valid[bus.resp_tag_bi];
    capture    = bus.resp_i & ~empty & ~slot_valid[bus.resp_tag_bi] & ~bypass;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      slot_valid  <= '0;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
      err_q       <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (release_en)
        rd_ptr <= rd_ptr + 1'b1;

      unique case ({push_ok, release_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Release and capture never target the same slot: capture requires the
      // slot empty, release of a non-bypassed head requires it full.
      if (release_en)
        slot_valid[head] <= 1'b0;
      if (capture)
        slot_valid[bus.resp_tag_bi] <= 1'b1;

      resp_q <= release_en;
      if (release_en)
        resp_data_q <= head_valid ? slot_data[head] : bus.resp_data_bi;

      err_q <= err_q | {err_empty, err_dup, err_full};
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the
  // pointers/count and the slot valid bits.
  always_ff @(posedge clk_i) begin
    if (push_ok)
      tag_fifo[wr_ptr] <= bus.tag_wdata_bi;
    if (capture)
      slot_data[bus.resp_tag_bi] <= bus.resp_data_bi;
  end

  assign bus.tag_full_o   = full;
  assign bus.count_o      = count;
  assign bus.resp_o       = resp_q;
  assign bus.resp_data_bo = resp_data_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_pavana_reorder_seq.sv
module tb_pavana_reorder_seq;
  localparam int TW    = 2;
  localparam int DW    = 32;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int SLOTS = 1 << TW;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pavana_reorder_seq_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .ORDER_DEPTH_LOG(DL)) bus ();

  pavana_reorder_seq #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .ORDER_DEPTH_LOG(DL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Reference model: issue-order queue of tags, parked responses per tag,
  // expected registered outputs.
  int              q[$];
  bit              mv[SLOTS];
  logic [DW-1:0]   md[SLOTS];
  logic [2:0]      me_err;
  logic            me_resp;
  logic [DW-1:0]   me_data;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("resp_o",       64'(bus.resp_o),       64'(me_resp));
    chk("resp_data_bo", 64'(bus.resp_data_bo), 64'(me_data));
    chk("count_o",      64'(bus.count_o),      64'(q.size()));
    chk("tag_full_o",   64'(bus.tag_full_o),   64'(q.size() == DEPTH));
    chk("err_o",        64'(bus.err_o),        64'(me_err));
    $display("t=%0t resp=%0b data=%08h count=%0d full=%0b err=%03b",
             $time, bus.resp_o, bus.resp_data_bo, bus.count_o, bus.tag_full_o, bus.err_o);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SLOTS; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    me_err  = '0;
    me_resp = 1'b0;
    me_data = '0;
  endtask

  // One clock of the sequencer's rules, applied to the model.
  task automatic model_step(input bit w, input int wt, input bit r, input int rt, input logic [DW-1:0] rd);
    int sz;
    int h;
    bit hv;
    bit byp;
    sz  = q.size();
    h   = (sz != 0) ? q[0] : 0;
    hv  = (sz != 0) ? mv[h] : 1'b0;
    byp = 1'b0;
    if (r) begin
      if (sz == 0)      me_err[2] = 1'b1;
      else if (mv[rt])  me_err[1] = 1'b1;
      else if (rt == h) byp = 1'b1;
      else begin
        mv[rt] = 1'b1;
        md[rt] = rd;
      end
    end
    me_resp = 1'b0;
    if (sz != 0 && hv) begin
      me_resp = 1'b1;
      me_data = md[h];
      mv[h]   = 1'b0;
      void'(q.pop_front());
    end else if (byp) begin
      me_resp = 1'b1;
      me_data = rd;
      void'(q.pop_front());
    end
    if (w) begin
      if (sz == DEPTH) me_err[0] = 1'b1;
      else             q.push_back(wt);
    end
  endtask

  task automatic step(input bit w, input int wt, input bit r, input int rt, input logic [DW-1:0] rd);
    @(negedge clk_i);
    bus.tag_wr_i     = w;
    bus.tag_wdata_bi = TW'(wt);
    bus.resp_i       = r;
    bus.resp_tag_bi  = TW'(rt);
    bus.resp_data_bi = rd;
    model_step(w, wt, r, rt, rd);
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic push(input int t);
    step(1, t, 0, 0, '0);
  endtask

  task automatic resp(input int t, input logic [DW-1:0] d);
    step(0, 0, 1, t, d);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk_i);
    bus.tag_wr_i = 1'b0;
    bus.resp_i   = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    bus.tag_wr_i     = 1'b0;
    bus.tag_wdata_bi = '0;
    bus.resp_i       = 1'b0;
    bus.resp_tag_bi  = '0;
    bus.resp_data_bi = '0;
    model_reset();

    // Reset state
    do_reset();
    idle(1);

    // In-order responses
    for (int i = 0; i < 3; i++) push(i);
    for (int i = 0; i < 3; i++) resp(i, 32'hA0 + i);
    idle(2);

    // Reverse-order responses
    do_reset();
    for (int i = 0; i < 4; i++) push(i);
    for (int i = 3; i >= 0; i--) resp(i, 32'hB0 + i);
    idle(5);

    // Full, dropped 9th push, drain, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i % SLOTS);
    push(1);
    for (int i = 0; i < DEPTH; i++) resp(i % SLOTS, 32'hD0 + i);
    for (int i = 0; i < DEPTH; i++) push((i + 2) % SLOTS);
    for (int i = 0; i < DEPTH; i++) resp((i + 2) % SLOTS, 32'hE0 + i);
    idle(2);

    // Response while empty; duplicate response
    do_reset();
    resp(1, 32'h55);
    push(0);
    push(1);
    resp(1, 32'hC1);
    resp(1, 32'hC2);
    idle(1);
    resp(0, 32'hC0);
    idle(3);

    // Push+release at full: push dropped, count drops by one
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i % SLOTS);
    step(1, 2, 1, 0, 32'hF0);
    idle(1);
    // Push+release at count 3: count unchanged
    do_reset();
    for (int i = 0; i < 3; i++) push(i);
    step(1, 3, 1, 0, 32'hF1);
    idle(1);
    for (int i = 1; i < 4; i++) resp(i, 32'hF1 + i);
    idle(2);

    // Reset mid-run with parked responses
    do_reset();
    for (int i = 0; i < 3; i++) push(i);
    resp(1, 32'h11);
    resp(2, 32'h22);
    do_reset();
    resp(0, 32'h33);
    idle(2);

    // Randomized traffic, two rounds
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bit w;
        bit r;
        int wt;
        int rt;
        w  = ($urandom_range(0, 2) != 0);
        wt = int'($urandom_range(0, SLOTS - 1));
        r  = ($urandom_range(0, 1) != 0);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          rt = q[$urandom_range(0, q.size() - 1)];
        else
          rt = int'($urandom_range(0, SLOTS - 1));
        step(w, wt, r, rt, $urandom);
      end
      idle(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pavana_reorder_seq.md
# pavana_reorder_seq

Parametrised response re-ordering sequencer for the out-of-order crossbar slave ports. It records the transaction tag of every accepted read request in issue order, parks out-of-order slave responses in per-tag slots, and releases them strictly in issue order, one per cycle, to the in-order crossbar core. It generalises the fixed 8-entry, 2-bit-tag sequencer with configurable tag width, data width and order depth, and adds occupancy reporting and sticky protocol-error detection.

## Interface
- TAG_WIDTH, 2, width of request/response tags; 2^TAG_WIDTH response slots
- DATA_WIDTH, 32, response data width
- ORDER_DEPTH_LOG, 3, tag FIFO depth = 2^ORDER_DEPTH_LOG entries

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- tag_wr_i  in  1  push issued read tag (slave req & ack & !cmd)
- tag_wdata_bi  in  TAG_WIDTH  tag of issued read
- tag_full_o  out  1  tag FIFO full (combinational from count)
- count_o  out  ORDER_DEPTH_LOG+1  outstanding reads in tag FIFO
- resp_i  in  1  out-of-order response valid from slave
- resp_tag_bi  in  TAG_WIDTH  tag of response
- resp_data_bi  in  DATA_WIDTH  response data
- resp_o  out  1  in-order response valid, registered, one-cycle pulse per response
- resp_data_bo  out  DATA_WIDTH  in-order response data, registered
- err_o  out  3  sticky errors: [0] push while full, [1] duplicate tag response, [2] response while FIFO empty

## Operation
- State: circular tag FIFO (wr ptr, rd ptr, count 0..2^ORDER_DEPTH_LOG); slot array of 2^TAG_WIDTH entries, each valid bit + DATA_WIDTH data.
- Push: tag_wr_i & !tag_full_o -> write tag at wr ptr, wr ptr+1 mod depth. tag_wr_i & tag_full_o -> push dropped, err_o[0] set. Full test uses count before this cycle's pop (push-while-full with simultaneous pop is still dropped).
- Response capture: resp_i with count==0 -> dropped, err_o[2] set. resp_i with slot[resp_tag_bi] valid -> dropped, err_o[1] set, existing slot contents untouched. Otherwise response written to slot unless it is released the same cycle by bypass.
- head = tag at rd ptr. release = count!=0 & (slot[head].valid | (resp_i & resp_tag_bi==head & !slot[head].valid)).
- Release: resp_o<=1, resp_data_bo<= slot data if slot valid else resp_data_bi (bypass); slot[head].valid<=0; rd ptr+1; count-1. No release -> resp_o<=0, resp_data_bo holds last value.
- Simultaneous push and release: count unchanged, both pointers advance.
- Pointers wrap modulo 2^ORDER_DEPTH_LOG; count is one bit wider to distinguish full from empty.
- Same tag outstanding twice in FIFO is permitted; the slot serves the earlier entry first; a second response before the first is released is a duplicate (err_o[1]).
- err_o bits clear only on reset.

## Timing
- Reset (rst_i low, async): resp_o=0, resp_data_bo=0, err_o=0, count_o=0, tag_full_o=0, all slots invalid, pointers 0. Deassertion takes effect on next rising edge.
- Response whose tag is head: resp_o high on the cycle after resp_i (latency 1).
- Parked responses: one release per cycle; N consecutive ready slots drain in N consecutive cycles, resp_o held high.
- Response to a non-head tag: released 1 cycle after its head predecessor releases, at the earliest.
- tag_full_o and count_o reflect registered count; no same-cycle effect of push/pop.
- Reset mid-operation discards all outstanding tags and parked data; no response emitted after reset.

## Test plan
- In-order: push tags 0,1,2; responses tag0 D=0xA0, tag1 0xA1, tag2 0xA2 on consecutive cycles -> resp_o high 3 cycles, data 0xA0,0xA1,0xA2, count_o 3->0.
- Reverse: push 0,1,2,3; responses 3,2,1,0 (0xB3..0xB0) -> nothing until tag0 arrives, then 0xB0,0xB1,0xB2,0xB3 on 4 consecutive cycles starting 1 cycle after tag0.
- Full/wrap: push 8 tags (default depth) -> tag_full_o=1, count_o=8; 9th push -> dropped, err_o=3'b001; drain all, push 8 more -> pointers wrap, order preserved.
- Errors: response with FIFO empty -> err_o[2]=1, resp_o stays 0; push tag1, tag0 outstanding, two tag1 responses 0xC1, 0xC2 before tag0 -> second dropped, err_o[1]=1, later release returns 0xC1.
- Simultaneous push+release at count=8: push dropped, err_o[0]=1, count_o 7; push+release at count=3 -> count_o stays 3.
- Reset mid-run: 2 responses parked, rst_i low 1 cycle -> all outputs 0 immediately, subsequent head response for old tag -> err_o[2]=1, no resp_o.
